// File: rtl/fifo_burst_reader_if.sv
// Command, FIFO-drain and output-stream signals of the burst reader.
// master is the reader's view; slave is the surrounding logic's view.
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (
        input  cmd_valid, cmd_len, fifo_empty, fifo_data, m_ready,
        output cmd_ready, fifo_rd_en, m_valid, m_data, m_last
    );

    modport slave (
        output cmd_valid, cmd_len, fifo_empty, fifo_data, m_ready,
        input  cmd_ready, fifo_rd_en, m_valid, m_data, m_last
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// Pulls cmd_len+1 words from a show-ahead FIFO per command into a 2-entry
// output buffer; fifo_rd_en depends only on registered state and fifo_empty.
//   state | meaning
//   IDLE  | waiting for a burst command, cmd_ready high
//   BURST | fetching words, fetch_left beats still to pop
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    fifo_burst_reader_if.master bus,
    output logic                busy
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [LEN_WIDTH:0] ONE = (LEN_WIDTH+1)'(1);

    state_t                state;
    logic                  cmd_ready_q;
    logic [LEN_WIDTH:0]    fetch_left;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic                  buf_last [2];

    logic rd_en;
    logic pop;
    logic final_fetch;

    assign rd_en       = (state == BURST) && !bus.fifo_empty && (occ < 2'd2);
    assign pop         = (occ != 2'd0) && bus.m_ready;
    assign final_fetch = rd_en && (fetch_left == ONE);

    assign bus.fifo_rd_en = rd_en;
    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.m_valid    = (occ != 2'd0);
    assign bus.m_data     = buf_data[0];
    assign bus.m_last     = buf_last[0];
    assign busy           = (state != IDLE) || (occ != 2'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            fetch_left  <= '0;
            occ         <= '0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        // one extra bit so an all-ones length still counts 2^LEN_WIDTH beats
                        fetch_left  <= {1'b0, bus.cmd_len} + ONE;
                        state       <= BURST;
                        cmd_ready_q <= 1'b0;
                    end
                end
                BURST: begin
                    if (rd_en) begin
                        fetch_left <= fetch_left - ONE;
                    end
                    if (final_fetch) begin
                        state       <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase

            // head is always entry 0; a pop shifts entry 1 forward
            case ({rd_en, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        buf_data[0] <= bus.fifo_data;
                        buf_last[0] <= final_fetch;
                    end else begin
                        buf_data[1] <= bus.fifo_data;
                        buf_last[1] <= final_fetch;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf_data[0] <= buf_data[1];
                    buf_last[0] <= buf_last[1];
                    occ         <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf_data[0] <= bus.fifo_data;
                        buf_last[0] <= final_fetch;
                    end else begin
                        buf_data[0] <= buf_data[1];
                        buf_last[0] <= buf_last[1];
                        buf_data[1] <= bus.fifo_data;
                        buf_last[1] <= final_fetch;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: a word-index model of accepted bursts
// checks every output beat, plus literal timing/data expectations per scenario.
module tb_fifo_burst_reader;
    logic clk;
    logic rst_n;
    logic busy;

    fifo_burst_reader_if #(.DATA_WIDTH(32), .LEN_WIDTH(8)) ifc ();

    fifo_burst_reader #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   idx;
        logic last;
    } exp_t;

    int total = 0;
    int bad   = 0;

    logic [31:0] words [$];
    logic [31:0] fq [$];
    exp_t        exp_q [$];
    int          popped = 0;
    int          ptr    = 0;

    int  cyc = 0;
    int  hs_cyc = 0;
    int  cr_rise = 0;
    int  rd_cnt = 0;
    int  beats_n = 0;
    int  lasts_n = 0;
    int  beat_cyc [$];
    logic [31:0] beat_dat [$];
    logic beat_lst [$];

    logic in_rst = 1'b0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic prev_last;
    logic prev_cr = 1'b1;

    logic pop_s;
    logic last_hs;
    logic last_mv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // model: every accepted command reserves the next cmd_len+1 FIFO words
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            if (ifc.fifo_rd_en) popped++;
            exp_q.delete();
            ptr        = popped;
            prev_stall = 1'b0;
            in_rst     = 1'b1;
        end else begin
            if (in_rst) begin
                chk("rst_m_valid", ifc.m_valid, 0);
                chk("rst_cmd_ready", ifc.cmd_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_fifo_rd_en", ifc.fifo_rd_en, 0);
                in_rst = 1'b0;
            end
            chk("no_read_when_empty", ifc.fifo_rd_en && ifc.fifo_empty, 0);
            chk("cmd_ready_vs_model", ifc.cmd_ready, popped == ptr);
            chk("busy_vs_model", busy, exp_q.size() != 0);
            if (prev_stall) begin
                chk("stall_valid_hold", ifc.m_valid, 1);
                chk("stall_data_hold", ifc.m_data, prev_data);
                chk("stall_last_hold", ifc.m_last, prev_last);
            end
            if (ifc.cmd_ready && !prev_cr) cr_rise = cyc;
            prev_cr = ifc.cmd_ready;
            if (ifc.m_valid && ifc.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", ifc.m_data, words[e.idx]);
                    chk("beat_last", ifc.m_last, e.last);
                end
                beats_n++;
                if (ifc.m_last) lasts_n++;
                beat_cyc.push_back(cyc);
                beat_dat.push_back(ifc.m_data);
                beat_lst.push_back(ifc.m_last);
            end
            if (ifc.fifo_rd_en) begin
                popped++;
                rd_cnt++;
                chk("fetch_within_burst", popped <= ptr, 1);
            end
            if (ifc.cmd_valid && ifc.cmd_ready) begin
                for (int i = 0; i <= int'(ifc.cmd_len); i++)
                    exp_q.push_back('{ptr + i, i == int'(ifc.cmd_len)});
                ptr    = ptr + int'(ifc.cmd_len) + 1;
                hs_cyc = cyc;
            end
            prev_stall = ifc.m_valid && !ifc.m_ready;
            prev_data  = ifc.m_data;
            prev_last  = ifc.m_last;
        end
    end

    task automatic refresh();
        ifc.fifo_empty = (fq.size() == 0);
        ifc.fifo_data  = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
    endtask

    task automatic fifo_push(input logic [31:0] w);
        fq.push_back(w);
        words.push_back(w);
        refresh();
    endtask

    task automatic tick();
        @(negedge clk);
        pop_s   = ifc.fifo_rd_en;
        last_hs = ifc.cmd_valid && ifc.cmd_ready;
        last_mv = ifc.m_valid;
        @(posedge clk);
        #1;
        if (pop_s && fq.size() != 0) fq.delete(0);
        refresh();
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic keep);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_len   = len;
        last_hs       = 1'b0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (last_hs) break;
        end
        if (!last_hs) chk("cmd_handshake_timeout", 0, 1);
        if (!keep) ifc.cmd_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (exp_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", 0, 1);
    endtask

    task automatic clear_stats();
        rd_cnt  = 0;
        beats_n = 0;
        lasts_n = 0;
        beat_cyc.delete();
        beat_dat.delete();
        beat_lst.delete();
    endtask

    initial begin
        int h1;
        rst_n         = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_len   = '0;
        ifc.m_ready   = 1'b1;
        refresh();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // single burst of 4
        clear_stats();
        for (int i = 0; i < 4; i++) fifo_push(32'hA0 + i);
        send_cmd(8'd3, 1'b0);
        drain(50);
        chk("single_beats", beats_n, 4);
        chk("single_rd_pulses", rd_cnt, 4);
        chk("single_cmd_ready_cycle", cr_rise, hs_cyc + 5);
        if (beats_n == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("single_beat_cycle", beat_cyc[i], hs_cyc + 2 + i);
                chk("single_beat_data", beat_dat[i], 32'hA0 + i);
                chk("single_beat_last", beat_lst[i], i == 3);
            end
        end

        // backpressure
        clear_stats();
        ifc.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_push(32'hB0 + i);
        send_cmd(8'd7, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("bp_rd_during_stall", rd_cnt, 2);
        chk("bp_valid_while_stalled", last_mv, 1);
        ifc.m_ready = 1'b1;
        drain(60);
        chk("bp_beats", beats_n, 8);
        chk("bp_lasts", lasts_n, 1);
        if (beats_n == 8) begin
            chk("bp_first_data", beat_dat[0], 32'hB0);
            chk("bp_final_data", beat_dat[7], 32'hB7);
            chk("bp_final_last", beat_lst[7], 1);
        end

        // FIFO runs dry mid-burst
        clear_stats();
        fifo_push(32'hC0);
        fifo_push(32'hC1);
        send_cmd(8'd4, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i >= 4) chk("uf_valid_low_in_gap", last_mv, 0);
        end
        for (int i = 2; i < 5; i++) fifo_push(32'hC0 + i);
        drain(50);
        chk("uf_beats", beats_n, 5);
        chk("uf_lasts", lasts_n, 1);
        if (beats_n == 5) chk("uf_fifth_last", beat_lst[4], 1);

        // back-to-back commands
        clear_stats();
        fifo_push(32'h11);
        fifo_push(32'h22);
        fifo_push(32'h33);
        send_cmd(8'd0, 1'b1);
        h1 = hs_cyc;
        send_cmd(8'd1, 1'b0);
        chk("b2b_second_accept", hs_cyc, h1 + 2);
        drain(50);
        chk("b2b_beats", beats_n, 3);
        if (beats_n == 3) begin
            chk("b2b_x_data", beat_dat[0], 32'h11);
            chk("b2b_x_last", beat_lst[0], 1);
            chk("b2b_y_last", beat_lst[1], 0);
            chk("b2b_z_data", beat_dat[2], 32'h33);
            chk("b2b_z_last", beat_lst[2], 1);
        end

        // maximum length
        clear_stats();
        for (int i = 0; i < 256; i++) fifo_push(32'h1000 + i);
        send_cmd(8'd255, 1'b0);
        drain(600);
        chk("max_beats", beats_n, 256);
        chk("max_lasts", lasts_n, 1);
        if (beats_n == 256) chk("max_final", {beat_lst[255], beat_dat[255][30:0]}, {1'b1, 31'h10FF});

        // reset in the middle of a burst
        clear_stats();
        for (int i = 0; i < 8; i++) fifo_push(32'h500 + i);
        send_cmd(8'd7, 1'b0);
        for (int n = 0; n < 50 && beats_n < 3; n++) tick();
        chk("rst_reached_3_beats", beats_n, 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
        send_cmd(8'd1, 1'b0);
        drain(50);
        chk("post_rst_beats", beats_n, 2);
        if (beats_n == 2) begin
            chk("post_rst_data0", beat_dat[0], 32'h505);
            chk("post_rst_data1", beat_dat[1], 32'h506);
            chk("post_rst_last", {beat_lst[0], beat_lst[1]}, 2'b01);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
